// File: rtl/inst_cache_pkg.sv
// Shared instruction-cache constants, address layout and fill-state encodings.
// The data cache reuses the IC_* state encodings.
package inst_cache_pkg;

  localparam int WORD_W     = 16;
  localparam int LINE_W     = 64;
  localparam int INDEX_BITS = 2;
  localparam int OFF_BITS   = 2;
  localparam int TAG_W      = WORD_W - INDEX_BITS - OFF_BITS;
  localparam int CNT_W      = 16;
  localparam int N_LINES    = 1 << INDEX_BITS;

  localparam logic [1:0] IC_IDLE  = 2'd0;
  localparam logic [1:0] IC_REQ   = 2'd1;
  localparam logic [1:0] IC_FETCH = 2'd2;

  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [INDEX_BITS-1:0] idx;
    logic [OFF_BITS-1:0]   off;
  } addr_t;

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFF_BITS-1:0] off);
    return line[off*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/valid/line storage: combinational read, one write port, flush-all.
// Valid bits clear asynchronously on reset; tag and data carry no reset.
module icache_array
  import inst_cache_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic [INDEX_BITS-1:0] i_rd_idx,
  output logic                  o_rd_valid,
  output logic [TAG_W-1:0]      o_rd_tag,
  output logic [LINE_W-1:0]     o_rd_line,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_idx,
  input  logic [TAG_W-1:0]      i_wr_tag,
  input  logic [LINE_W-1:0]     i_wr_line
);

  logic [N_LINES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag  [N_LINES];
  logic [LINE_W-1:0]  r_line [N_LINES];

  // Flush wins over a same-cycle install.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_line[i_wr_idx] <= i_wr_line;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_line  = r_line[i_rd_idx];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hit, one-line fill per miss.
// Fetch is held off (cpu_ready=0) while a fill is outstanding; arbiter launch waits for ready_inst.
module inst_cache
  import inst_cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_read,
  input  logic [WORD_W-1:0] cpu_addr,
  output logic [WORD_W-1:0] cpu_data,
  output logic              cpu_ready,
  input  logic              flush,
  output logic              read_inst,
  output logic [WORD_W-1:0] addr_inst,
  input  logic [LINE_W-1:0] res_inst,
  input  logic              ready_inst,
  input  logic              ack_inst,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int MIDX_LO = OFF_BITS;
  localparam int MTAG_LO = OFF_BITS + INDEX_BITS;

  logic [1:0]        r_state;
  logic              r_read_inst;
  logic              r_drop;
  logic [WORD_W-1:0] r_miss_addr;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  addr_t             w_addr;
  logic              w_valid;
  logic [TAG_W-1:0]  w_tag;
  logic [LINE_W-1:0] w_line;
  logic              w_idle;
  logic              w_hit;
  logic              w_miss;
  logic              w_fill;

  assign w_addr = cpu_addr;
  assign w_idle = (r_state == IC_IDLE);
  assign w_hit  = cpu_read & w_valid & (w_tag == w_addr.tag) & w_idle;
  assign w_miss = cpu_read & ~w_hit & w_idle;
  // A flush coinciding with the ack must also suppress the install.
  assign w_fill = (r_state == IC_FETCH) & ack_inst & ~r_drop & ~flush;

  icache_array u_array (
    .i_clk      (clk),
    .i_rst_n    (reset_n),
    .i_flush    (flush),
    .i_rd_idx   (w_addr.idx),
    .o_rd_valid (w_valid),
    .o_rd_tag   (w_tag),
    .o_rd_line  (w_line),
    .i_wr_en    (w_fill),
    .i_wr_idx   (r_miss_addr[MTAG_LO-1:MIDX_LO]),
    .i_wr_tag   (r_miss_addr[WORD_W-1:MTAG_LO]),
    .i_wr_line  (res_inst)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IC_IDLE;
      r_read_inst <= 1'b0;
      r_drop      <= 1'b0;
      r_miss_addr <= '0;
      r_miss_cnt  <= '0;
    end else begin
      case (r_state)
        IC_IDLE: begin
          if (w_miss) begin
            r_miss_addr <= {w_addr.tag, w_addr.idx, {OFF_BITS{1'b0}}};
            if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
            if (ready_inst) begin
              r_read_inst <= 1'b1;
              r_state     <= IC_FETCH;
            end else begin
              r_state     <= IC_REQ;
            end
          end
        end
        IC_REQ: begin
          if (ready_inst) begin
            r_read_inst <= 1'b1;
            r_state     <= IC_FETCH;
          end
        end
        IC_FETCH: begin
          if (ack_inst) begin
            r_read_inst <= 1'b0;
            r_drop      <= 1'b0;
            r_state     <= IC_IDLE;
          end else if (flush) begin
            r_drop      <= 1'b1;
          end
        end
        default: begin
          r_read_inst <= 1'b0;
          r_state     <= IC_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_cnt <= '0;
    end else if (w_hit && r_hit_cnt != '1) begin
      r_hit_cnt <= r_hit_cnt + 1'b1;
    end
  end

  assign cpu_ready  = w_hit;
  assign cpu_data   = line_word(w_line, w_addr.off);
  assign read_inst  = r_read_inst;
  assign addr_inst  = w_idle ? '0 : r_miss_addr;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

endmodule

// File: tb/tb_inst_cache.sv
// Scoreboarded bench for inst_cache: expected fetch words queued at request, popped on cpu_ready.
module tb_inst_cache;
  import inst_cache_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cpu_read;
  logic [WORD_W-1:0] cpu_addr;
  logic [WORD_W-1:0] cpu_data;
  logic              cpu_ready;
  logic              flush;
  logic              read_inst;
  logic [WORD_W-1:0] addr_inst;
  logic [LINE_W-1:0] res_inst;
  logic              ready_inst;
  logic              ack_inst;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  int n_chk = 0;
  int n_fail = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  logic [63:0] mem [logic [15:0]];

  inst_cache dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_read   (cpu_read),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_ready  (cpu_ready),
    .flush      (flush),
    .read_inst  (read_inst),
    .addr_inst  (addr_inst),
    .res_inst   (res_inst),
    .ready_inst (ready_inst),
    .ack_inst   (ack_inst),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] line_for(input logic [15:0] la);
    if (mem.exists(la)) return mem[la];
    return {la ^ 16'hF00F, la ^ 16'h0F0F, la ^ 16'h00FF, la};
  endfunction

  function automatic logic [15:0] word_of(input logic [15:0] a);
    logic [63:0] l;
    l = line_for({a[15:2], 2'b00});
    return l[a[1:0]*16 +: 16];
  endfunction

  always @(negedge clk) begin
    if (reset_n === 1'b1 && cpu_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexp_ready", {63'd0, cpu_ready}, 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("cpu_data", {48'd0, cpu_data}, {48'd0, mon_exp});
      end
    end
  end

  task automatic check_counts();
    check_eq("hit_count", {48'd0, hit_count}, 64'(exp_hits));
    check_eq("miss_count", {48'd0, miss_count}, 64'(exp_misses));
  endtask

  // Returns at the negedge of the first cycle read_inst is seen high.
  task automatic wait_rd(input logic [15:0] a);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = (read_inst === 1'b1);
    end
    check_eq("rd_inst_up", {63'd0, read_inst}, 64'd1);
    check_eq("addr_inst", {48'd0, addr_inst}, {48'd0, a[15:2], 2'b00});
  endtask

  task automatic serve(input logic [15:0] a, input int lat);
    wait_rd(a);
    for (int i = 0; i < lat; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("rd_hold", {63'd0, read_inst}, 64'd1);
    end
    @(posedge clk); #1;
    ack_inst = 1'b1;
    res_inst = line_for({a[15:2], 2'b00});
    @(posedge clk); #1;
    ack_inst = 1'b0;
    res_inst = '0;
  endtask

  // Called just after a posedge; returns just after a posedge with cpu_read low.
  task automatic access(input logic [15:0] a, input bit exp_hit, input int lat, input int busy);
    cpu_addr = a;
    cpu_read = 1'b1;
    if (busy > 0) ready_inst = 1'b0;
    exp_q.push_back(word_of(a));
    @(negedge clk);
    check_eq("lookup_hit", {63'd0, cpu_ready}, {63'd0, exp_hit});
    if (!exp_hit) begin
      exp_misses++;
      for (int i = 1; i < busy; i++) begin
        @(negedge clk);
        check_eq("req_rd_low", {63'd0, read_inst}, 64'd0);
      end
      if (busy > 0) begin
        @(posedge clk); #1;
        ready_inst = 1'b1;
        @(negedge clk);
        check_eq("rd_low_at_rdy", {63'd0, read_inst}, 64'd0);
      end
      serve(a, lat);
      @(negedge clk);
      check_eq("retry_hit", {63'd0, cpu_ready}, 64'd1);
    end
    exp_hits++;
    @(posedge clk); #1;
    cpu_read = 1'b0;
    check_counts();
  endtask

  task automatic flushed_miss(input logic [15:0] a, input bit with_ack);
    cpu_addr = a;
    cpu_read = 1'b1;
    @(negedge clk);
    check_eq("fm_lookup", {63'd0, cpu_ready}, 64'd0);
    exp_misses++;
    wait_rd(a);
    @(posedge clk); #1;
    flush = 1'b1;
    if (!with_ack) begin
      @(posedge clk); #1;
      flush = 1'b0;
    end
    ack_inst = 1'b1;
    res_inst = line_for({a[15:2], 2'b00});
    @(posedge clk); #1;
    flush = 1'b0;
    ack_inst = 1'b0;
    res_inst = '0;
    @(negedge clk);
    check_eq("flush_noinst", {63'd0, cpu_ready}, 64'd0);
    exp_misses++;
    exp_q.push_back(word_of(a));
    serve(a, 1);
    @(negedge clk);
    check_eq("fm_retry_hit", {63'd0, cpu_ready}, 64'd1);
    exp_hits++;
    @(posedge clk); #1;
    cpu_read = 1'b0;
    check_counts();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    cpu_read = 1'b0;
    cpu_addr = '0;
    flush = 1'b0;
    res_inst = '0;
    ready_inst = 1'b1;
    ack_inst = 1'b0;
    mem[16'h0010] = 64'h4444_3333_2222_1111;
    mem[16'h0050] = 64'hAAAA_BBBB_CCCC_DDDD;
    #2;
    check_eq("rst_read_inst", {63'd0, read_inst}, 64'd0);
    check_eq("rst_addr_inst", {48'd0, addr_inst}, 64'd0);
    check_eq("rst_ready", {63'd0, cpu_ready}, 64'd0);
    check_counts();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Cold miss then hit, then same-line hits
    access(16'h0012, 1'b0, 3, 0);
    access(16'h0010, 1'b1, 0, 0);
    access(16'h0013, 1'b1, 0, 0);

    // Conflict eviction at index 0
    access(16'h0052, 1'b0, 2, 0);
    access(16'h0012, 1'b0, 0, 0);
    check_eq("miss_after_evict", {48'd0, miss_count}, 64'd3);

    // Busy arbiter: ready_inst low for 5 cycles
    access(16'h0038, 1'b0, 1, 5);
    access(16'h0039, 1'b1, 0, 0);

    // Flush in FETCH drops the line and invalidates everything
    flushed_miss(16'h0094, 1'b0);
    access(16'h0095, 1'b1, 0, 0);
    access(16'h0012, 1'b0, 0, 0);
    access(16'h0038, 1'b0, 0, 0);
    flushed_miss(16'h0064, 1'b1);

    // Async reset mid-FETCH, then a late ack
    cpu_addr = 16'h00A4;
    cpu_read = 1'b1;
    @(negedge clk);
    check_eq("rst_test_lookup", {63'd0, cpu_ready}, 64'd0);
    wait_rd(16'h00A4);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check_eq("arst_read_inst", {63'd0, read_inst}, 64'd0);
    check_eq("arst_addr_inst", {48'd0, addr_inst}, 64'd0);
    check_eq("arst_ready", {63'd0, cpu_ready}, 64'd0);
    exp_hits = 0;
    exp_misses = 0;
    check_counts();
    cpu_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    ack_inst = 1'b1;
    res_inst = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    ack_inst = 1'b0;
    res_inst = '0;
    @(negedge clk);
    check_eq("late_ack_rd", {63'd0, read_inst}, 64'd0);
    check_eq("late_ack_addr", {48'd0, addr_inst}, 64'd0);
    check_counts();
    @(posedge clk); #1;
    access(16'h00A4, 1'b0, 0, 0);
    access(16'h0010, 1'b0, 1, 0);

    repeat (2) @(posedge clk);
    check_eq("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
